// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register with a valid/ready handshake, synchronous
//   flush, an optional 2-entry skid buffer and a saturating stall counter.
//   A stage built from this block can stall or be squashed without losing or
//   duplicating beats. Beats leave in arrival order, one cycle after acceptance.
//
// Parameters
//   PAYLOAD_W  payload width (concatenated stage fields)
//   RESET_VAL  payload value presented after reset or flush (e.g. NOP encoding)
//   SKID       1: two entries, o_ready registered (no i_ready->o_ready path)
//              0: one entry, o_ready = empty | i_ready (combinational)
//   CNT_W      stall counter width
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   i_flush      in   synchronous squash of all held entries (highest priority)
//   i_valid      in   upstream beat valid
//   o_ready      out  this stage can accept a beat
//   i_data       in   upstream payload
//   o_valid      out  downstream beat valid
//   i_ready      in   downstream accepts the head beat
//   o_data       out  head entry payload
//   i_cnt_clr    in   synchronous clear of the stall counter
//   o_stall_cnt  out  saturating count of cycles with o_valid=1 and i_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W = 64,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = {PAYLOAD_W{1'b0}},
  parameter bit                   SKID      = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q,  main_d;
  logic [PAYLOAD_W-1:0] skid_q,  skid_d;
  logic                 rdy_q,   rdy_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  logic push_s;
  logic pop_s;
  logic stall_s;

  assign push_s  = i_valid & o_ready;
  assign pop_s   = o_valid & i_ready;
  assign stall_s = o_valid & ~i_ready;

  assign o_valid     = (state_q != ST_EMPTY);
  assign o_data      = main_q;
  assign o_stall_cnt = cnt_q;

  // rdy_q is low throughout reset and rises on the first edge after release.
  // With a skid buffer it is the full-registered ready; without one it only
  // gates the combinational ready so that o_ready stays low during reset.
  generate
    if (SKID) begin : g_ready_skid
      assign o_ready = rdy_q;
    end else begin : g_ready_comb
      assign o_ready = rdy_q & ((state_q == ST_EMPTY) | i_ready);
    end
  endgenerate

  // Next-state and entry update; flush overrides any push or pop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            main_d  = i_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_d = ST_ONE;
            main_d  = i_data;
          end else if (push_s && SKID) begin
            // Downstream stalled: park the new beat behind the head entry.
            state_d = ST_TWO;
            skid_d  = i_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // o_ready is low here, so only a pop can happen.
          if (pop_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = RESET_VAL;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty stage.
          state_d = ST_EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  // Ready for the next cycle is a pure function of the next state.
  always_comb begin
    if (SKID) begin
      rdy_d = (state_d != ST_TWO);
    end else begin
      rdy_d = 1'b1;
    end
  end

  // Stall counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, entry, ready and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_stage_reg_chk #(
    .PAYLOAD_W (PAYLOAD_W),
    .SKID      (SKID)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_flush),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .state_two (state_q == ST_TWO),
    .o_data    (o_data)
  );

endmodule

// -----------------------------------------------------------------------------
// pipe_stage_reg_chk
//   Protocol properties of pipe_stage_reg.
//   Ports: clock/reset, handshake signals, head payload and a "two entries
//   held" indication from the stage.
// -----------------------------------------------------------------------------
module pipe_stage_reg_chk #(
  parameter int unsigned PAYLOAD_W = 64,
  parameter bit          SKID      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 i_flush,
  input logic                 i_ready,
  input logic                 o_valid,
  input logic                 o_ready,
  input logic                 state_two,
  input logic [PAYLOAD_W-1:0] o_data
);

  // A stalled head beat stays valid and unchanged unless squashed.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (o_valid && !i_ready && !i_flush) |=> (o_valid && (o_data == $past(o_data))));

  // Without a skid buffer the second entry is never occupied.
  a_no_two: assert property (@(posedge clk) disable iff (!rst)
    (!SKID) |-> !state_two);

  // With both entries full the stage must refuse new beats.
  a_full_not_ready: assert property (@(posedge clk) disable iff (!rst)
    state_two |-> !o_ready);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share one stimulus stream
//   inst0: SKID=1, CNT_W=16   inst1: SKID=0, CNT_W=16   inst2: SKID=1, CNT_W=4
// Each instance is mirrored by a small FIFO model (occupancy + capacity rule).
module tb_pipe_stage_reg;

  localparam logic [63:0] RV = 64'h0000_0013_0000_0013;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_valid;
  logic        i_ready;
  logic        i_cnt_clr;
  logic [63:0] i_data;

  logic [2:0]       o_ready_v;
  logic [2:0]       o_valid_v;
  logic [2:0][63:0] o_data_v;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;
  logic [3:0]       cnt2;

  int checks;
  int errors;

  // Reference model state per instance
  bit          m_skid [3];
  int          m_max  [3];
  logic [63:0] m_buf  [3][2];
  int          m_n    [3];
  int          m_cnt  [3];
  bit          m_live [3];

  pipe_stage_reg #(.PAYLOAD_W(64), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_v[0]),
    .i_data(i_data), .o_valid(o_valid_v[0]), .i_ready(i_ready), .o_data(o_data_v[0]),
    .i_cnt_clr(i_cnt_clr), .o_stall_cnt(cnt0));

  pipe_stage_reg #(.PAYLOAD_W(64), .RESET_VAL(RV), .SKID(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_v[1]),
    .i_data(i_data), .o_valid(o_valid_v[1]), .i_ready(i_ready), .o_data(o_data_v[1]),
    .i_cnt_clr(i_cnt_clr), .o_stall_cnt(cnt1));

  pipe_stage_reg #(.PAYLOAD_W(64), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_v[2]),
    .i_data(i_data), .o_valid(o_valid_v[2]), .i_ready(i_ready), .o_data(o_data_v[2]),
    .i_cnt_clr(i_cnt_clr), .o_stall_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_cnt(input int i);
    if (i == 0) return int'(cnt0);
    else if (i == 1) return int'(cnt1);
    else return int'(cnt2);
  endfunction

  function automatic bit m_valid(input int i);
    return (m_n[i] > 0);
  endfunction

  function automatic logic [63:0] m_head(input int i);
    return (m_n[i] > 0) ? m_buf[i][0] : RV;
  endfunction

  // Capacity rule: skid stage takes a beat while it holds fewer than two;
  // single-entry stage takes one when empty or when its head leaves now.
  function automatic bit m_ready(input int i);
    if (!m_live[i]) return 1'b0;
    if (m_skid[i]) return (m_n[i] < 2);
    return (m_n[i] == 0) || i_ready;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_cnt[i] = 0; m_live[i] = 1'b0;
    end
  endtask

  task automatic apply(input bit v, input logic [63:0] d, input bit r, input bit fl, input bit clr);
    i_valid = v; i_data = d; i_ready = r; i_flush = fl; i_cnt_clr = clr;
  endtask

  // Advance one clock; model decisions use the inputs held across the edge.
  task automatic tick();
    bit push [3];
    bit pop  [3];
    bit stl  [3];
    for (int i = 0; i < 3; i++) begin
      push[i] = i_valid && m_ready(i);
      pop[i]  = m_valid(i) && i_ready;
      stl[i]  = m_valid(i) && !i_ready;
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (i_cnt_clr) m_cnt[i] = 0;
        else if (stl[i] && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
        if (i_flush) begin
          m_n[i] = 0;
        end else begin
          if (pop[i]) begin
            m_buf[i][0] = m_buf[i][1];
            m_n[i] = m_n[i] - 1;
          end
          if (push[i]) begin
            m_buf[i][m_n[i]] = i_data;
            m_n[i] = m_n[i] + 1;
          end
        end
        m_live[i] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_v[i] !== 1'b0 || o_ready_v[i] !== 1'b0 || o_data_v[i] !== RV || dut_cnt(i) != 0) begin
        errors++;
        $display("FAIL reset_state inst%0d got v=%b r=%b d=%h c=%0d exp v=0 r=0 d=%h c=0",
                 i, o_valid_v[i], o_ready_v[i], o_data_v[i], dut_cnt(i), RV);
      end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_ready_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL release_ready_low inst%0d got %b exp 0", i, o_ready_v[i]);
      end
    end
    tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_ready_v[i] !== 1'b1 || o_valid_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL release_ready_high inst%0d got r=%b v=%b exp r=1 v=0", i, o_ready_v[i], o_valid_v[i]);
      end
    end
  endtask

  task automatic test_stream();
    apply(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      apply(k <= 8, 64'(k), 1'b1, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_ready_v[i] !== 1'b1 || dut_cnt(i) != 0) begin
          errors++;
          $display("FAIL stream_ready_cnt inst%0d k=%0d got r=%b c=%0d exp r=1 c=0", i, k, o_ready_v[i], dut_cnt(i));
        end
        checks++;
        if (k == 1 && o_valid_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL stream_first inst%0d got v=%b exp v=0", i, o_valid_v[i]);
        end else if (k > 1 && (o_valid_v[i] !== 1'b1 || o_data_v[i] !== 64'(k - 1))) begin
          errors++;
          $display("FAIL stream_data inst%0d got v=%b d=%h exp v=1 d=%h", i, o_valid_v[i], o_data_v[i], 64'(k - 1));
        end
      end
      tick();
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL stream_drained inst%0d got v=%b exp 0", i, o_valid_v[i]);
      end
    end
  endtask

  task automatic test_skid_and_stall();
    apply(1'b1, 64'hA, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 64'hB, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 3; i += 2) begin
        checks++;
        if (o_ready_v[i] !== 1'b0 || o_valid_v[i] !== 1'b1 || o_data_v[i] !== 64'hA || dut_cnt(i) != k - 1) begin
          errors++;
          $display("FAIL skid_hold inst%0d k=%0d got r=%b v=%b d=%h c=%0d exp r=0 v=1 d=a c=%0d",
                   i, k, o_ready_v[i], o_valid_v[i], o_data_v[i], dut_cnt(i), k - 1);
        end
      end
      tick();
    end
    apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_cnt(i) != 5) begin
        errors++;
        $display("FAIL stall_cnt5 inst%0d got %0d exp 5", i, dut_cnt(i));
      end
    end
    tick();
    apply(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_cnt(i) != 0) begin
        errors++;
        $display("FAIL stall_clr inst%0d got %0d exp 0", i, dut_cnt(i));
      end
    end
    tick();
    #1;
    for (int i = 0; i < 3; i += 2) begin
      checks++;
      if (o_valid_v[i] !== 1'b1 || o_data_v[i] !== 64'hB || o_ready_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL skid_second inst%0d got v=%b d=%h r=%b exp v=1 d=b r=1", i, o_valid_v[i], o_data_v[i], o_ready_v[i]);
      end
    end
    checks++;
    if (o_valid_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL noskid_single got v=%b exp 0", o_valid_v[1]);
    end
    tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_v[i] !== 1'b0 || dut_cnt(i) != 0) begin
        errors++;
        $display("FAIL skid_drained inst%0d got v=%b c=%0d exp v=0 c=0", i, o_valid_v[i], dut_cnt(i));
      end
    end
  endtask

  task automatic test_flush();
    apply(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 64'hC, 1'b1, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_v[i] !== 1'b1 || o_data_v[i] !== 64'hA) begin
        errors++;
        $display("FAIL flush_pre inst%0d got v=%b d=%h exp v=1 d=a", i, o_valid_v[i], o_data_v[i]);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_valid_v[i] !== 1'b0 || o_data_v[i] !== RV || o_ready_v[i] !== 1'b1) begin
          errors++;
          $display("FAIL flush_empty inst%0d k=%0d got v=%b d=%h r=%b exp v=0 d=%h r=1",
                   i, k, o_valid_v[i], o_data_v[i], o_ready_v[i], RV);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    apply(1'b1, 64'h55, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 21; k++) begin
      apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (int'(cnt2) != ((k - 1) > 15 ? 15 : (k - 1)) || int'(cnt0) != k - 1) begin
        errors++;
        $display("FAIL saturate k=%0d got c2=%0d c0=%0d exp c2=%0d c0=%0d",
                 k, cnt2, cnt0, ((k - 1) > 15 ? 15 : (k - 1)), k - 1);
      end
      if (k < 21) tick();
    end
    apply(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    apply(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 64'h88, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_v[i] !== 1'b0 || o_ready_v[i] !== 1'b0 || o_data_v[i] !== RV || dut_cnt(i) != 0) begin
        errors++;
        $display("FAIL async_reset inst%0d got v=%b r=%b d=%h c=%0d exp v=0 r=0 d=%h c=0",
                 i, o_valid_v[i], o_ready_v[i], o_data_v[i], dut_cnt(i), RV);
      end
    end
    tick();
    rst = 1'b1;
    apply(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_ready_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_release_low inst%0d got %b exp 0", i, o_ready_v[i]);
      end
    end
    tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_ready_v[i] !== 1'b1 || o_valid_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_release_high inst%0d got r=%b v=%b exp r=1 v=0", i, o_ready_v[i], o_valid_v[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_valid_v[i] !== m_valid(i) || o_data_v[i] !== m_head(i) ||
            o_ready_v[i] !== m_ready(i) || dut_cnt(i) != m_cnt[i]) begin
          errors++;
          $display("FAIL random inst%0d n=%0d got v=%b d=%h r=%b c=%0d exp v=%b d=%h r=%b c=%0d",
                   i, n, o_valid_v[i], o_data_v[i], o_ready_v[i], dut_cnt(i),
                   m_valid(i), m_head(i), m_ready(i), m_cnt[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_skid[0] = 1'b1; m_skid[1] = 1'b0; m_skid[2] = 1'b1;
    m_max[0]  = 65535; m_max[1] = 65535; m_max[2] = 15;
    for (int i = 0; i < 3; i++) begin
      m_buf[i][0] = 64'd0;
      m_buf[i][1] = 64'd0;
    end
    test_reset();
    test_stream();
    test_skid_and_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
